// File: rtl/eth_phy_link_ctrl.sv
// rtl/eth_phy_link_ctrl.sv - 10G PHY receive link bring-up sequencer (optional LINK_CTRL_HOLDOFF_EN drop filter)
module eth_phy_link_ctrl #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int STABLE_CYCLES   = 125,
    parameter int MAX_RETRIES     = 7,
    parameter int HOLDOFF_CYCLES  = 4
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    input  logic       enable,
    input  logic       phy_rx_block_lock,
    input  logic       phy_rx_status,
    input  logic       phy_rx_high_ber,
    input  logic       phy_serdes_rx_reset_req,
    output logic       phy_rst_out,
    output logic       link_up,
    output logic       link_fail,
    output logic [2:0] state_out,
    output logic [3:0] retry_count,
    output logic [7:0] link_down_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_UP        = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int RW = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_DONE = SW'(STABLE_CYCLES);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    down_q, down_d;
    logic          phy_rst_q, link_up_q, link_fail_q;

    logic          qual;
    logic          drop;
    logic          fail_attempt;
    logic          go_down;
    logic [3:0]    retry_inc;
    logic [SW-1:0] stable_inc;

`ifdef LINK_CTRL_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_DONE = HW'(HOLDOFF_CYCLES);
    logic [HW-1:0] hold_q, hold_d, hold_inc;
`else
    logic unused_holdoff;
    assign unused_holdoff = |HOLDOFF_CYCLES;
`endif

    assign qual = phy_rx_block_lock && phy_rx_status;
    assign drop = !phy_rx_block_lock || phy_rx_high_ber || phy_serdes_rx_reset_req;

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        timer_d      = timer_q;
        stable_d     = stable_q;
        retry_d      = retry_q;
        down_d       = down_q;
        fail_attempt = 1'b0;
        go_down      = 1'b0;
        retry_inc    = retry_q + 4'd1;
        stable_inc   = qual ? stable_q + SW'(1) : '0;
`ifdef LINK_CTRL_HOLDOFF_EN
        hold_d       = hold_q;
        hold_inc     = hold_q + HW'(1);
`endif

        if (!enable) begin
            state_d   = ST_IDLE;
            rst_cnt_d = '0;
            timer_d   = '0;
            stable_d  = '0;
            retry_d   = '0;
`ifdef LINK_CTRL_HOLDOFF_EN
            hold_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                end
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = ST_WAIT_LOCK;
                        rst_cnt_d = '0;
                        timer_d   = '0;
                        stable_d  = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    timer_d  = (timer_q == TIMER_LAST) ? timer_q : timer_q + TW'(1);
                    stable_d = stable_inc;
                    // serdes request outranks a stable count completing on the same cycle
                    if (phy_serdes_rx_reset_req) begin
                        fail_attempt = 1'b1;
                    end else if (stable_inc == STABLE_DONE) begin
                        state_d = ST_UP;
                        retry_d = '0;
`ifdef LINK_CTRL_HOLDOFF_EN
                        hold_d  = '0;
`endif
                    end else if (timer_q == TIMER_LAST) begin
                        fail_attempt = 1'b1;
                    end
                    if (fail_attempt) begin
                        retry_d   = retry_inc;
                        state_d   = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
                        rst_cnt_d = '0;
                        timer_d   = '0;
                        stable_d  = '0;
                    end
                end
                ST_UP: begin
`ifdef LINK_CTRL_HOLDOFF_EN
                    if (drop) begin
                        if (hold_inc == HOLD_DONE) begin
                            go_down = 1'b1;
                            hold_d  = '0;
                        end else begin
                            hold_d  = hold_inc;
                        end
                    end else begin
                        hold_d = '0;
                    end
`else
                    go_down = drop;
`endif
                    if (go_down) begin
                        down_d    = (down_q == 8'hFF) ? down_q : down_q + 8'd1;
                        state_d   = ST_RESET;
                        rst_cnt_d = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            timer_q     <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            down_q      <= '0;
            phy_rst_q   <= 1'b1;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            down_q      <= down_d;
            // flags follow the next state so they change on the same edge as state_out
            phy_rst_q   <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
            link_up_q   <= (state_d == ST_UP);
            link_fail_q <= (state_d == ST_FAIL);
        end
    end

`ifdef LINK_CTRL_HOLDOFF_EN
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign phy_rst_out     = phy_rst_q;
    assign link_up         = link_up_q;
    assign link_fail       = link_fail_q;
    assign state_out       = state_q;
    assign retry_count     = retry_q;
    assign link_down_count = down_q;

endmodule

// File: tb/tb_eth_phy_link_ctrl.sv
// tb/tb_eth_phy_link_ctrl.sv - directed bench with a phase/age reference model for eth_phy_link_ctrl
module tb_eth_phy_link_ctrl;

    localparam int RST_HOLD = 4;
    localparam int LOCK_TO  = 64;
    localparam int STABLE   = 8;
    localparam int MAXR     = 3;
`ifdef LINK_CTRL_HOLDOFF_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif

    localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_UP = 3, P_FAIL = 4;

    typedef struct {
        int phase;
        int age;
        int run;
        int retry;
        int down;
        int hold;
    } model_t;

    logic       rx_clk_tb = 1'b0;
    logic       rx_rst_tb = 1'b1;
    logic       enable = 1'b0;
    logic       lock = 1'b0;
    logic       status = 1'b0;
    logic       ber = 1'b0;
    logic       serdes = 1'b0;
    logic       phy_rst_out;
    logic       link_up;
    logic       link_fail;
    logic [2:0] state_out;
    logic [3:0] retry_count;
    logic [7:0] link_down_count;

    int     n_cmp = 0;
    int     n_bad = 0;
    logic   cmp_on = 1'b0;
    model_t m;

    eth_phy_link_ctrl #(
        .RST_HOLD_CYCLES(RST_HOLD),
        .LOCK_TIMEOUT   (LOCK_TO),
        .STABLE_CYCLES  (STABLE),
        .MAX_RETRIES    (MAXR),
        .HOLDOFF_CYCLES (4)
    ) dut (
        .rx_clk                 (rx_clk_tb),
        .rx_rst                 (rx_rst_tb),
        .enable                 (enable),
        .phy_rx_block_lock      (lock),
        .phy_rx_status          (status),
        .phy_rx_high_ber        (ber),
        .phy_serdes_rx_reset_req(serdes),
        .phy_rst_out            (phy_rst_out),
        .link_up                (link_up),
        .link_fail              (link_fail),
        .state_out              (state_out),
        .retry_count            (retry_count),
        .link_down_count        (link_down_count)
    );

    always #5 rx_clk_tb = ~rx_clk_tb;

    function automatic model_t model_reset();
        model_t r;
        r.phase = P_IDLE; r.age = 0; r.run = 0; r.retry = 0; r.down = 0; r.hold = 0;
        return r;
    endfunction

    // age = cycles spent in the current phase, run = consecutive lock&status samples
    function automatic model_t model_next(model_t c, logic en, logic lk, logic st, logic hb, logic sr);
        model_t n;
        logic failed;
        n = c;
        failed = 1'b0;
        if (!en) begin
            n.phase = P_IDLE; n.age = 0; n.run = 0; n.retry = 0; n.hold = 0;
            return n;
        end
        case (c.phase)
            P_IDLE: begin
                n.phase = P_RESET; n.age = 0;
            end
            P_RESET: begin
                n.age = c.age + 1;
                if (n.age == RST_HOLD) begin
                    n.phase = P_WAIT; n.age = 0; n.run = 0;
                end
            end
            P_WAIT: begin
                n.age = c.age + 1;
                n.run = (lk && st) ? c.run + 1 : 0;
                if (sr) failed = 1'b1;
                else if (n.run == STABLE) begin
                    n.phase = P_UP; n.retry = 0; n.hold = 0;
                end else if (n.age == LOCK_TO) failed = 1'b1;
                if (failed) begin
                    n.retry = c.retry + 1;
                    n.phase = (n.retry == MAXR) ? P_FAIL : P_RESET;
                    n.age = 0;
                end
            end
            P_UP: begin
                if (!lk || hb || sr) begin
                    n.hold = c.hold + 1;
                    if (n.hold >= HOLD) begin
                        n.down = (c.down < 255) ? c.down + 1 : 255;
                        n.phase = P_RESET; n.age = 0; n.hold = 0;
                    end
                end else begin
                    n.hold = 0;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge rx_clk_tb or posedge rx_rst_tb) begin
        if (rx_rst_tb) m <= model_reset();
        else           m <= model_next(m, enable, lock, status, ber, serdes);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rx_clk_tb) begin
        if (cmp_on) begin
            check("model.state", int'(state_out), m.phase);
            check("model.phy_rst", int'(phy_rst_out),
                  (m.phase == P_IDLE || m.phase == P_RESET || m.phase == P_FAIL) ? 1 : 0);
            check("model.link_up", int'(link_up), (m.phase == P_UP) ? 1 : 0);
            check("model.link_fail", int'(link_fail), (m.phase == P_FAIL) ? 1 : 0);
            check("model.retry", int'(retry_count), m.retry);
            check("model.down", int'(link_down_count), m.down);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge rx_clk_tb);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".state"}, int'(state_out), 0);
        check({tag, ".phy_rst"}, int'(phy_rst_out), 1);
        check({tag, ".link_up"}, int'(link_up), 0);
        check({tag, ".link_fail"}, int'(link_fail), 0);
        check({tag, ".retry"}, int'(retry_count), 0);
        check({tag, ".down"}, int'(link_down_count), 0);
    endtask

    initial begin
        repeat (2) @(negedge rx_clk_tb);
        cmp_on = 1'b1;
        #1;
        check_reset_values("por");
        rx_rst_tb = 1'b0;
        tick(1);
        check("idle_hold", int'(state_out), 0);

        // normal bring-up with lock and status already good
        lock = 1'b1; status = 1'b1; enable = 1'b1;
        tick(1);
        check("bu.reset_entry", int'(state_out), 1);
        tick(3);
        check("bu.rst_still_high", int'(phy_rst_out), 1);
        tick(1);
        check("bu.rst_low_after_5", int'(phy_rst_out), 0);
        check("bu.wait_state", int'(state_out), 2);
        tick(7);
        check("bu.not_up_at_7", int'(link_up), 0);
        tick(1);
        check("bu.up_at_8", int'(link_up), 1);
        check("bu.state_up", int'(state_out), 3);
        check("bu.retry0", int'(retry_count), 0);

        // link drops and saturation of the drop counter
        ber = 1'b1; tick(HOLD); ber = 1'b0;
        check("drop.link_up", int'(link_up), 0);
        check("drop.state", int'(state_out), 1);
        check("drop.count1", int'(link_down_count), 1);
        tick(12);
        check("drop.relock", int'(state_out), 3);
        for (int i = 0; i < 299; i++) begin
            ber = 1'b1; tick(HOLD); ber = 1'b0;
            tick(12);
        end
        check("drop.sat255", int'(link_down_count), 255);

        // serdes reset request inside WAIT_LOCK
        enable = 1'b0; lock = 1'b0;
        tick(1);
        check("sr.idle", int'(state_out), 0);
        check("sr.down_kept", int'(link_down_count), 255);
        enable = 1'b1;
        tick(5);
        check("sr.wait", int'(state_out), 2);
        tick(10);
        serdes = 1'b1; tick(1); serdes = 1'b0;
        check("sr.to_reset", int'(state_out), 1);
        check("sr.retry1", int'(retry_count), 1);
        tick(4);
        lock = 1'b1;
        tick(7);
        check("sr.wait_again", int'(state_out), 2);
        serdes = 1'b1; tick(1); serdes = 1'b0;
        check("sr.beats_stable", int'(state_out), 1);
        check("sr.retry2", int'(retry_count), 2);
        check("sr.not_up", int'(link_up), 0);

        // lock flapping exhausts retries
        enable = 1'b0;
        tick(1);
        check("flap.idle_retry0", int'(retry_count), 0);
        lock = 1'b0; enable = 1'b1;
        for (int i = 0; i < 210; i++) begin
            if (i % 5 == 0) lock = ~lock;
            tick(1);
        end
        check("flap.link_fail", int'(link_fail), 1);
        check("flap.state", int'(state_out), 4);
        check("flap.retry3", int'(retry_count), 3);
        check("flap.phy_rst", int'(phy_rst_out), 1);
        enable = 1'b0;
        tick(1);
        check("flap.idle", int'(state_out), 0);
        check("flap.fail_clr", int'(link_fail), 0);

        // asynchronous reset mid-WAIT_LOCK and mid-UP
        lock = 1'b0; enable = 1'b1;
        tick(8);
        check("ar.in_wait", int'(state_out), 2);
        rx_rst_tb = 1'b1;
        #1;
        check_reset_values("ar_wait");
        tick(1);
        rx_rst_tb = 1'b0;
        lock = 1'b1;
        tick(13);
        check("ar.in_up", int'(state_out), 3);
        rx_rst_tb = 1'b1;
        #1;
        check_reset_values("ar_up");
        tick(1);
        rx_rst_tb = 1'b0;

`ifdef LINK_CTRL_HOLDOFF_EN
        tick(13);
        check("ho.up", int'(state_out), 3);
        ber = 1'b1; tick(3); ber = 1'b0;
        tick(1);
        check("ho.short_stays_up", int'(link_up), 1);
        check("ho.short_count", int'(link_down_count), 0);
        ber = 1'b1; tick(4); ber = 1'b0;
        check("ho.long_reset", int'(state_out), 1);
        check("ho.long_count", int'(link_down_count), 1);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
